vote_tally_scheduler: RTL and testbench
=======================================

Name: vote_tally_scheduler

Overview:
- Shares one digit-serial BCD increment path between NUM_CAND candidate vote requesters.
- Round-robin arbitration picks one requester per transaction.
- Increments that candidate's DIGITS-digit BCD tally, one digit per cycle, with ripple carry; acks the requester.
- Sits between the debounced candidate buttons and the display/result mux of the ballot box.

Parameters:
- NUM_CAND, 4, number of candidates/requesters (2..8)
- DIGITS, 3, BCD digits per tally (1..4)

Ports:
- clock  in  1  system clock
- reset  in  1  reset; synchronous, active-high
- vote_req  in  NUM_CAND  level request per candidate, held until ack
- vote_ack  out  NUM_CAND  one-hot, one-cycle pulse, vote recorded
- busy  out  1  high whenever state != IDLE
- rd_sel  in  $clog2(NUM_CAND)  tally read index
- rd_count  out  4*DIGITS  BCD tally of rd_sel, registered, digit 0 = LSBs
- sat  out  NUM_CAND  sticky per-candidate saturation flag

Behaviour:
- Reset:
  - All tallies = 0; vote_ack = 0; sat = 0; rd_count = 0; busy = 0.
  - Round-robin pointer = 0; armed = all ones; state = IDLE.
  - Reset mid-operation aborts the transaction. No ack is issued and the partial tally is discarded.
- Arming:
  - eligible[i] = vote_req[i] & armed[i].
  - armed[i] clears on the cycle vote_ack[i] pulses.
  - armed[i] re-sets on any cycle vote_req[i] is sampled low.
  - One press = exactly one vote.
- FSM states: IDLE, INC, DONE.
- IDLE:
  - If eligible != 0, grant the first eligible index at or after the pointer, wrapping modulo NUM_CAND.
  - Latch the grant index; copy its tally to a work register; digit index d = 0; carry = 1; go to INC.
  - If eligible == 0, stay in IDLE.
- INC (exactly DIGITS cycles):
  - Each cycle: s = work[d] + carry.
  - If s == 10, work[d] = 0 and carry = 1; otherwise work[d] = s and carry = 0.
  - Then d++.
  - After digit DIGITS-1, go to DONE.
- DONE (1 cycle):
  - If the final carry = 1 (tally was all 9s): the tally is left at all 9s, not written as 0, and sat[grant] = 1.
  - Otherwise the tally is written with the work value.
  - vote_ack[grant] = 1 for this cycle only.
  - Pointer = grant+1, wrapping to 0 at NUM_CAND; go to IDLE.
- Latency and throughput:
  - Request sampled at IDLE edge k gives ack high during cycle k+DIGITS+1.
  - Minimum spacing between transactions is DIGITS+2 cycles.
- Simultaneous requests: served in round-robin order from the pointer. No requester waits more than NUM_CAND-1 transactions.
- Requests dropped before ack:
  - Once granted, the transaction completes regardless.
  - The ack still pulses.
- Read port:
  - rd_count <= tally[rd_sel] each cycle, one-cycle latency.
  - A read of the candidate written in DONE in the same cycle returns the pre-update value.
- Invariant: every stored digit is always in 0..9.

Optional Feature:
- VOTE_TOTAL_EN, compiled in:
  - Adds output total_count [4*(DIGITS+1)], reset 0, with one extra BCD digit.
  - It is incremented by the same serial path in extra INC cycles, so INC lasts DIGITS+1+DIGITS+1 cycles; latency grows accordingly.
  - total_count saturates independently at all 9s.
- Not compiled in: the port is absent and timing is as above.

Decomposition:
- Package vote_pkg:
  - BCD_MAX = 4'd9.
  - State enum {IDLE, INC, DONE}.
  - bcd_digit_t = logic [3:0].
- Sub-module bcd_digit_step:
  - Combinational: (digit, carry_in) -> (digit_out, carry_out).
  - Shared by the tally and total paths.

Test Plan (NUM_CAND=4, DIGITS=3):
- Reset, then a single request on candidate 2 held until ack:
  - vote_ack = 4'b0100 exactly 4 cycles after the sampling edge.
  - rd_sel = 2 reads 0x001; busy is high for 4 cycles.
- Candidate 1 tally preloaded to 0x199 by 199 presses, then one more vote:
  - rd_count = 0x200, carry ripples through two digits; sat[1] = 0.
- Candidate 0 at 0x999, then a vote:
  - Ack still pulses; tally stays 0x999; sat[0] = 1.
  - After reset, tally = 0 and sat = 0.
- All four requests asserted together from pointer = 0:
  - Acks in order 0, 1, 2, 3, each 5 cycles apart; each tally = 0x001.
- Candidate 3 held high for 50 cycles:
  - Exactly one ack; tally = 0x001.
  - Release and press again gives 0x002.
- Reset asserted during INC of candidate 1 (tally 0x009):
  - No ack; all tallies = 0; state is IDLE on the next cycle.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and constants for the vote tally scheduler and its BCD step.
package vote_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    INC,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit plus carry-in; a 9 with carry wraps to 0 and carries out.
module bcd_digit_step
  import vote_pkg::*;
(
  input  bcd_digit_t i_digit,
  input  logic       i_carry,
  output bcd_digit_t o_digit,
  output logic       o_carry
);

  always_comb begin
    o_digit = i_digit;
    o_carry = 1'b0;
    if (i_carry) begin
      if (i_digit == BCD_MAX) begin
        o_digit = '0;
        o_carry = 1'b1;
      end else begin
        o_digit = i_digit + 4'd1;
      end
    end
  end

endmodule

// File: rtl/vote_tally_scheduler.sv
// Round-robin shared digit-serial BCD incrementer for per-candidate vote tallies.
// Optional running total of all votes when VOTE_TOTAL_EN is defined.
module vote_tally_scheduler
  import vote_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int DIGITS   = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CAND-1:0]         vote_req,
  output logic [NUM_CAND-1:0]         vote_ack,
  output logic                        busy,
  input  logic [$clog2(NUM_CAND)-1:0] rd_sel,
  output logic [4*DIGITS-1:0]         rd_count,
  output logic [NUM_CAND-1:0]         sat,
`ifdef VOTE_TOTAL_EN
  output logic [4*(DIGITS+1)-1:0]     total_count,
`endif
  output state_t                      dbg_state
);

  localparam int SEL_W = $clog2(NUM_CAND);
  localparam int TW    = 4*DIGITS;
`ifdef VOTE_TOTAL_EN
  localparam int XW = 4*(DIGITS+1);
  // Tally digits, one turnaround cycle, then the DIGITS+1 total digits.
  localparam logic [3:0] LAST_STEP = 4'(2*DIGITS+1);
  localparam logic [3:0] TURN_STEP = 4'(DIGITS);
`else
  localparam logic [3:0] LAST_STEP = 4'(DIGITS-1);
`endif

  state_t                r_state, w_state_next;
  logic [SEL_W-1:0]      r_ptr, r_grant, w_grant;
  logic [3:0]            r_step;
  logic                  r_carry, w_tally_carry;
  logic [TW-1:0]         r_work;
  logic [TW+3:0]         w_work_rot;
  logic [TW-1:0]         r_tally [NUM_CAND];
  logic [NUM_CAND-1:0]   r_armed, r_ack, r_sat, w_eligible, w_ack_next;
  logic [TW-1:0]         r_rd;
  logic                  w_found, w_rd_ok;
  logic [SEL_W-1:0]      w_idx;
  bcd_digit_t            w_step_din, w_dout;
  logic                  w_cout;

  assign w_eligible = vote_req & r_armed;
  assign w_rd_ok    = {1'b0, rd_sel} < (SEL_W+1)'(NUM_CAND);
  assign w_work_rot = {w_dout, r_work};

  // First eligible requester at or after the pointer, wrapping.
  always_comb begin
    w_grant = r_ptr;
    w_found = 1'b0;
    w_idx   = r_ptr;
    for (int k = 0; k < NUM_CAND; k++) begin
      if (!w_found && w_eligible[w_idx]) begin
        w_grant = w_idx;
        w_found = 1'b1;
      end
      w_idx = (w_idx == SEL_W'(NUM_CAND-1)) ? '0 : w_idx + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ack_next   = '0;
    case (r_state)
      IDLE: if (w_found) w_state_next = INC;
      INC:  if (r_step == LAST_STEP) w_state_next = DONE;
      DONE: begin
        w_state_next = IDLE;
        w_ack_next   = NUM_CAND'(1) << r_grant;
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef VOTE_TOTAL_EN
  logic          r_tcarry, w_tot_phase;
  logic [XW-1:0] r_tot_work, r_total;
  logic [XW+3:0] w_tot_rot;

  assign w_tot_phase   = r_step > TURN_STEP;
  assign w_step_din    = w_tot_phase ? r_tot_work[3:0] : r_work[3:0];
  assign w_tot_rot     = {w_dout, r_tot_work};
  assign w_tally_carry = r_tcarry;
  assign total_count   = r_total;
`else
  assign w_step_din    = r_work[3:0];
  assign w_tally_carry = r_carry;
`endif

  bcd_digit_step u_step (
    .i_digit (w_step_din),
    .i_carry (r_carry),
    .o_digit (w_dout),
    .o_carry (w_cout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_step  <= '0;
      r_carry <= 1'b0;
      r_work  <= '0;
      r_armed <= '1;
      r_ack   <= '0;
      r_sat   <= '0;
      r_rd    <= '0;
      for (int i = 0; i < NUM_CAND; i++) r_tally[i] <= '0;
`ifdef VOTE_TOTAL_EN
      r_tcarry   <= 1'b0;
      r_tot_work <= '0;
      r_total    <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_ack   <= w_ack_next;
      // A press is consumed by its ack and re-armed only once released.
      r_armed <= ~vote_req | (r_armed & ~w_ack_next);
      r_rd    <= w_rd_ok ? r_tally[rd_sel] : '0;
      case (r_state)
        IDLE: if (w_found) begin
          r_grant <= w_grant;
          r_work  <= r_tally[w_grant];
          r_step  <= '0;
          r_carry <= 1'b1;
`ifdef VOTE_TOTAL_EN
          r_tot_work <= r_total;
`endif
        end
        INC: begin
          r_step  <= r_step + 4'd1;
          r_carry <= w_cout;
`ifdef VOTE_TOTAL_EN
          if (r_step < TURN_STEP) begin
            r_work <= w_work_rot[TW+3:4];
          end else if (r_step == TURN_STEP) begin
            r_tcarry <= r_carry;
            r_carry  <= 1'b1;
          end else begin
            r_tot_work <= w_tot_rot[XW+3:4];
          end
`else
          r_work <= w_work_rot[TW+3:4];
`endif
        end
        DONE: begin
          // A carry out of the top digit means the tally was all 9s: hold it.
          if (w_tally_carry) r_sat[r_grant] <= 1'b1;
          else               r_tally[r_grant] <= r_work;
`ifdef VOTE_TOTAL_EN
          if (!r_carry) r_total <= r_tot_work;
`endif
          r_ptr <= (r_grant == SEL_W'(NUM_CAND-1)) ? '0 : r_grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign vote_ack  = r_ack;
  assign busy      = (r_state != IDLE);
  assign rd_count  = r_rd;
  assign sat       = r_sat;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_vote_tally_scheduler.sv
// Directed bench for vote_tally_scheduler (NUM_CAND=4, DIGITS=3), default build.
module tb_vote_tally_scheduler;
  import vote_pkg::*;

  localparam int NC = 4;
  localparam int DG = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NC-1:0]   vote_req = '0;
  logic [NC-1:0]   vote_ack;
  logic            busy;
  logic [1:0]      rd_sel = '0;
  logic [4*DG-1:0] rd_count;
  logic [NC-1:0]   sat;
  state_t          dbg_state;

  int n_checks = 0;
  int n_fails  = 0;

  vote_tally_scheduler #(.NUM_CAND(NC), .DIGITS(DG)) dut (
    .clock     (clock),
    .reset     (reset),
    .vote_req  (vote_req),
    .vote_ack  (vote_ack),
    .busy      (busy),
    .rd_sel    (rd_sel),
    .rd_count  (rd_count),
    .sat       (sat),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vote_req = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  // Press candidate c, hold until ack (bounded), release, let it re-arm.
  task automatic vote(input int c, output int lat, output int busy_n, output logic [NC-1:0] ack_v);
    int  cnt;
    bit  got;
    cnt = 0; got = 0; lat = 0; busy_n = 0; ack_v = '0;
    vote_req[c] = 1'b1;
    while (!got && cnt < 40) begin
      @(negedge clock);
      cnt++;
      if (busy) busy_n++;
      if (vote_ack != '0) begin
        got = 1; lat = cnt; ack_v = vote_ack;
      end
    end
    vote_req[c] = 1'b0;
    check_eq("ack_seen", 32'(got), 32'd1);
    @(negedge clock);
  endtask

  task automatic read_tally(input int c, output logic [4*DG-1:0] v);
    rd_sel = 2'(c);
    @(negedge clock);
    v = rd_count;
  endtask

  initial begin
    int              lat, bn, cnt, n;
    logic [NC-1:0]   av;
    logic [4*DG-1:0] rv;
    int              ack_t [NC];
    logic [NC-1:0]   ack_v [NC];

    do_reset();
    check_eq("rst_ack", 32'(vote_ack), 32'h0);
    check_eq("rst_sat", 32'(sat), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_rd", 32'(rd_count), 32'h0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));

    // Single vote on candidate 2.
    vote(2, lat, bn, av);
    check_eq("c2_latency", 32'(lat), 32'd5);
    check_eq("c2_ack", 32'(av), 32'h4);
    check_eq("c2_busy_cycles", 32'(bn), 32'd4);
    read_tally(2, rv);
    check_eq("c2_tally", 32'(rv), 32'h001);

    // Candidate 1 to 199, then ripple into 200.
    for (int i = 0; i < 199; i++) vote(1, lat, bn, av);
    read_tally(1, rv);
    check_eq("c1_199", 32'(rv), 32'h199);
    vote(1, lat, bn, av);
    read_tally(1, rv);
    check_eq("c1_200", 32'(rv), 32'h200);
    check_eq("c1_sat", 32'(sat[1]), 32'd0);

    // Candidate 0 to 999, then saturate.
    for (int i = 0; i < 999; i++) vote(0, lat, bn, av);
    read_tally(0, rv);
    check_eq("c0_999", 32'(rv), 32'h999);
    check_eq("c0_sat_pre", 32'(sat), 32'h0);
    vote(0, lat, bn, av);
    check_eq("c0_sat_ack", 32'(av), 32'h1);
    read_tally(0, rv);
    check_eq("c0_held", 32'(rv), 32'h999);
    check_eq("c0_sat", 32'(sat), 32'h1);
    do_reset();
    read_tally(0, rv);
    check_eq("c0_after_rst", 32'(rv), 32'h0);
    check_eq("sat_after_rst", 32'(sat), 32'h0);
    read_tally(1, rv);
    check_eq("c1_after_rst", 32'(rv), 32'h0);

    // All four at once from pointer 0.
    for (int i = 0; i < NC; i++) begin ack_t[i] = 0; ack_v[i] = '0; end
    vote_req = 4'b1111;
    n = 0; cnt = 0;
    while (n < NC && cnt < 60) begin
      @(negedge clock);
      cnt++;
      if (vote_ack != '0) begin
        ack_t[n] = cnt; ack_v[n] = vote_ack;
        vote_req = vote_req & ~vote_ack;
        n++;
      end
    end
    vote_req = '0;
    @(negedge clock);
    check_eq("rr_acks", 32'(n), 32'd4);
    for (int i = 0; i < NC; i++) begin
      check_eq("rr_order", 32'(ack_v[i]), 32'(4'b0001 << i));
      check_eq("rr_time", 32'(ack_t[i]), 32'(5 * (i + 1)));
      read_tally(i, rv);
      check_eq("rr_tally", 32'(rv), 32'h001);
    end

    // Candidate 3 held for 50 cycles gives exactly one vote.
    do_reset();
    vote_req[3] = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (vote_ack != '0) n++;
    end
    vote_req[3] = 1'b0;
    @(negedge clock);
    check_eq("hold_acks", 32'(n), 32'd1);
    read_tally(3, rv);
    check_eq("hold_tally", 32'(rv), 32'h001);
    vote(3, lat, bn, av);
    read_tally(3, rv);
    check_eq("repress_tally", 32'(rv), 32'h002);

    // Reset during INC of candidate 1 at 009.
    do_reset();
    for (int i = 0; i < 9; i++) vote(1, lat, bn, av);
    read_tally(1, rv);
    check_eq("c1_009", 32'(rv), 32'h009);
    vote_req[1] = 1'b1;
    @(negedge clock);
    check_eq("mid_busy", 32'(busy), 32'd1);
    @(negedge clock);
    check_eq("mid_state", 32'(dbg_state), 32'(INC));
    reset = 1'b1;
    vote_req = '0;
    @(negedge clock);
    reset = 1'b0;
    check_eq("abort_state", 32'(dbg_state), 32'(IDLE));
    check_eq("abort_busy", 32'(busy), 32'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (vote_ack != '0) n++;
      @(negedge clock);
    end
    check_eq("abort_no_ack", 32'(n), 32'd0);
    for (int i = 0; i < NC; i++) begin
      read_tally(i, rv);
      check_eq("abort_tally", 32'(rv), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
